// File: rtl/duram_arb_pkg.sv
// Shared types and constants for the duram port-A arbiter.
// State encoding, owner IDs and the burst beat counter width.
package duram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam logic OWN_REQ0 = 1'b0;
    localparam logic OWN_REQ1 = 1'b1;

    localparam int BEAT_CNT_W = 8;

    // Value of the beat counter on the last beat of a tenure.
    function automatic logic [BEAT_CNT_W-1:0] burst_last(input int max_burst);
        return BEAT_CNT_W'(max_burst - 1);
    endfunction

endpackage

// File: rtl/duram_port_arb.sv
// duram_port_arb: shares duram port A between requesters 0 and 1 with
// burst tenures of up to MAX_BURST beats and 1-cycle read latency.
//
// Ports:
//   Clk, Reset            clock and async active-high reset
//   reqN/weN/addrN/wdataN requester N beat request, write flag, address, data
//   ackN                  beat accepted this cycle (combinational)
//   rvalidN               rdata valid for requester N (registered)
//   rdata                 pass-through of ram_q
//   ram_address/ram_data/ram_wren/ram_q  duram port A
//
// Optional macro DURAM_ARB_FIXED_PRIO_EN: an IDLE tie always grants
// requester 0 instead of round-robin on the last owner.
import duram_arb_pkg::*;

module duram_port_arb #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_BURST  = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [BEAT_CNT_W-1:0] LP_LAST = burst_last(MAX_BURST);

    arb_state_t              r_state;
    logic [BEAT_CNT_W-1:0]   r_beat_cnt;
    logic                    r_rvalid0;
    logic                    r_rvalid1;

    logic                    w_ack0;
    logic                    w_ack1;
    logic                    w_sel1;
    logic                    w_tie_to0;
    logic                    w_last0;
    logic                    w_last1;

    assign w_ack0 = (r_state == ST_OWN0) & req0;
    assign w_ack1 = (r_state == ST_OWN1) & req1;
    assign w_sel1 = (r_state == ST_OWN1);

    // Tenure ends on this beat only if the other side is waiting.
    assign w_last0 = w_ack0 & (r_beat_cnt == LP_LAST);
    assign w_last1 = w_ack1 & (r_beat_cnt == LP_LAST);

`ifdef DURAM_ARB_FIXED_PRIO_EN
    assign w_tie_to0 = 1'b1;
`else
    logic r_last_owner;
    assign w_tie_to0 = (r_last_owner == OWN_REQ1);
`endif

    assign ack0        = w_ack0;
    assign ack1        = w_ack1;
    assign rvalid0     = r_rvalid0;
    assign rvalid1     = r_rvalid1;
    assign rdata       = ram_q;
    assign ram_address = w_sel1 ? addr1 : addr0;
    assign ram_data    = w_sel1 ? wdata1 : wdata0;
    assign ram_wren    = (w_ack0 & we0) | (w_ack1 & we1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
`ifndef DURAM_ARB_FIXED_PRIO_EN
            r_last_owner <= OWN_REQ1;
`endif
        end else begin
            r_rvalid0 <= w_ack0 & ~we0;
            r_rvalid1 <= w_ack1 & ~we1;
            unique case (r_state)
                ST_IDLE: begin
                    r_beat_cnt <= '0;
                    if (req0 && (!req1 || w_tie_to0)) begin
                        r_state <= ST_OWN0;
`ifndef DURAM_ARB_FIXED_PRIO_EN
                        r_last_owner <= OWN_REQ0;
`endif
                    end else if (req1) begin
                        r_state <= ST_OWN1;
`ifndef DURAM_ARB_FIXED_PRIO_EN
                        r_last_owner <= OWN_REQ1;
`endif
                    end
                end
                ST_OWN0: begin
                    if (!req0 || (w_last0 && req1)) begin
                        r_beat_cnt <= '0;
                        if (req1) begin
                            r_state <= ST_OWN1;
`ifndef DURAM_ARB_FIXED_PRIO_EN
                            r_last_owner <= OWN_REQ1;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_last0) begin
                        r_beat_cnt <= '0;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                ST_OWN1: begin
                    if (!req1 || (w_last1 && req0)) begin
                        r_beat_cnt <= '0;
                        if (req0) begin
                            r_state <= ST_OWN0;
`ifndef DURAM_ARB_FIXED_PRIO_EN
                            r_last_owner <= OWN_REQ0;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_last1) begin
                        r_beat_cnt <= '0;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_duram_port_arb.sv
// Directed bench for duram_port_arb with a no_change duram port-A model.
// Inputs change #1 after posedge; outputs are sampled on negedge.
`timescale 1ns/1ps

module tb_duram_port_arb;

    localparam int DW = 36;
    localparam int AW = 9;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, rvalid0, rvalid1;
    logic [DW-1:0] rdata, ram_data, ram_q;
    logic [AW-1:0] ram_address;
    logic          ram_wren;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    duram_port_arb #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_BURST (MB)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .ack0       (ack0),
        .ack1       (ack1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata      (rdata),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q)
    );

    // duram port A, no_change mode: q holds on writes.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        else          ram_q <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic edge_in();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) edge_in();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) edge_in();
        rst = 1'b0;
    endtask

    logic [1:0] exp_acks;
    logic       exp_tie1;

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 9'h055; addr1 = 9'h0AA;
        wdata0 = 36'hA5A5A5A5A; wdata1 = 36'h5A5A5A5A5;
        ram_q = '0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;

        // Reset values
        repeat (2) edge_in();
        @(negedge clk);
        chk("rst_ack", {62'd0, ack1, ack0}, 64'd0);
        chk("rst_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
        chk("rst_wren", {63'd0, ram_wren}, 64'd0);
        chk("rst_addr", {55'd0, ram_address}, 64'h055);
        chk("rst_data", {28'd0, ram_data}, 64'hA5A5A5A5A);
        edge_in();
        rst = 1'b0;

        // 1: first write beat, acked one cycle after req
        edge_in();
        req0 = 1; we0 = 1; addr0 = 9'h010; wdata0 = 36'h123456789;
        @(negedge clk);
        chk("t1_idle_noack", {63'd0, ack0}, 64'd0);
        edge_in();
        @(negedge clk);
        chk("t1_ack0", {63'd0, ack0}, 64'd1);
        chk("t1_wren", {63'd0, ram_wren}, 64'd1);
        chk("t1_addr", {55'd0, ram_address}, 64'h010);
        chk("t1_data", {28'd0, ram_data}, 64'h123456789);
        edge_in();
        req0 = 0;
        @(negedge clk);
        chk("t1_no_rvalid", {63'd0, rvalid0}, 64'd0);
        go_idle();

        // 2: read back
        req0 = 1; we0 = 0; addr0 = 9'h010;
        edge_in();
        @(negedge clk);
        chk("t2_ack0", {63'd0, ack0}, 64'd1);
        chk("t2_wren0", {63'd0, ram_wren}, 64'd0);
        chk("t2_rv_early", {63'd0, rvalid0}, 64'd0);
        edge_in();
        req0 = 0;
        @(negedge clk);
        chk("t2_rvalid0", {63'd0, rvalid0}, 64'd1);
        chk("t2_rvalid1", {63'd0, rvalid1}, 64'd0);
        chk("t2_rdata", {28'd0, rdata}, 64'h123456789);
        edge_in();
        @(negedge clk);
        chk("t2_rv_drop", {63'd0, rvalid0}, 64'd0);
        go_idle();

        // 4: tie after reset, then second tie
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        edge_in();
        @(negedge clk);
        chk("t4_tie1", {62'd0, ack1, ack0}, 64'd1);
        edge_in();
        go_idle();
        req0 = 1; req1 = 1;
        edge_in();
        @(negedge clk);
`ifdef DURAM_ARB_FIXED_PRIO_EN
        exp_tie1 = 1'b0;
`else
        exp_tie1 = 1'b1;
`endif
        chk("t4_tie2", {62'd0, ack1, ack0}, {62'd0, exp_tie1, ~exp_tie1});
        edge_in();
        go_idle();

        // 3: both held, alternating bursts of MB beats
        we0 = 1; we1 = 1;
        req0 = 1; req1 = 1;
        for (int i = 0; i <= 4*MB; i++) begin
            @(negedge clk);
            if (i == 0) exp_acks = 2'b00;
            else if ((((i - 1) / MB) % 2) == 0) exp_acks = 2'b01;
            else exp_acks = 2'b10;
            chk($sformatf("t3_c%0d", i), {62'd0, ack1, ack0},
                {62'd0, exp_acks});
            edge_in();
        end
        go_idle();

        // 5: only req1, 20 consecutive beats across burst limits
        we1 = 0;
        req1 = 1;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            exp_acks = (i == 0) ? 2'b00 : 2'b10;
            chk($sformatf("t5_c%0d", i), {62'd0, ack1, ack0},
                {62'd0, exp_acks});
            edge_in();
        end
        go_idle();

        // 6: reset during read-ack cycle drops the beat
        req0 = 1; we0 = 0; addr0 = 9'h010;
        edge_in();
        @(negedge clk);
        chk("t6_ack0", {63'd0, ack0}, 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_ack_rst", {63'd0, ack0}, 64'd0);
        edge_in();
        @(negedge clk);
        chk("t6_rvalid0", {63'd0, rvalid0}, 64'd0);
        chk("t6_wren", {63'd0, ram_wren}, 64'd0);
        edge_in();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_idle", {63'd0, ack0}, 64'd0);
        edge_in();
        @(negedge clk);
        chk("t6_regrant", {63'd0, ack0}, 64'd1);
        go_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
